// File: rtl/memory_stage.sv
// Memory-access stage: latches execute results and performs at most one data-memory transaction per instruction.
// Defining MEM_TIMEOUT_EN enables a watchdog that aborts any transaction longer than TIMEOUT cycles.

`ifndef STAT_OK
`define STAT_OK 4'd1
`endif
`ifndef STAT_BUBBLE
`define STAT_BUBBLE 4'd5
`endif
`ifndef STAT_RESET
`define STAT_RESET 4'd6
`endif

module memory_stage #(
    parameter int          ADDR_W    = 64,
    parameter logic [63:0] MEM_BYTES = 64'd8192,
    parameter logic [3:0]  STAT_ADR  = 4'd3,
    parameter int          TIMEOUT   = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              stall_i,
    input  logic              bubble_i,
    input  logic [3:0]        icode_i,
    input  logic [3:0]        stat_i,
    input  logic [63:0]       valE_i,
    input  logic [63:0]       valA_i,
    input  logic [3:0]        dstE_i,
    input  logic [3:0]        dstM_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [63:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic              mem_rvalid_i,
    input  logic [63:0]       mem_rdata_i,
    output logic              mem_busy_o,
    output logic [3:0]        icode_o,
    output logic [3:0]        stat_o,
    output logic [63:0]       valE_o,
    output logic [63:0]       valM_o,
    output logic [3:0]        dstE_o,
    output logic [3:0]        dstM_o
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {IDLE, REQ, RWAIT} state_e;

    state_e            state_q, state_d;
    logic [3:0]        icode_q, stat_q, dstE_q, dstM_q;
    logic [63:0]       valE_q, valM_q;
    logic              memWe_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [63:0]       memWdata_q;

    logic        isRead, isWrite, access, fault, start, load, timeout;
    logic [63:0] accAddr;

    // Access decode looks at the incoming instruction so that the fault verdict and
    // the request fields are registered together with the stage register.
    always_comb begin
        isRead  = 1'b0;
        isWrite = 1'b0;
        accAddr = valE_i;
        case (icode_i)
            I_MRMOVQ:         isRead = 1'b1;
            I_POPQ, I_RET: begin
                isRead  = 1'b1;
                accAddr = valA_i;
            end
            I_RMMOVQ, I_PUSHQ, I_CALL: isWrite = 1'b1;
            default: ;
        endcase
    end

    assign access = (isRead | isWrite) && (stat_i == `STAT_OK);
    assign fault  = access && (accAddr > MEM_BYTES - 64'd8);
    assign start  = access && !fault;
    assign load   = (state_q == IDLE) && !stall_i;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmoCnt_q;
    logic             done;

    assign done    = (state_q == REQ && mem_ready_i && memWe_q) || (state_q == RWAIT && mem_rvalid_i);
    assign timeout = (state_q != IDLE) && !done && (tmoCnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || state_q == IDLE) begin
            tmoCnt_q <= '0;
        end else begin
            tmoCnt_q <= tmoCnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load && !bubble_i && start) state_d = REQ;
            REQ:     if (mem_ready_i) state_d = memWe_q ? IDLE : RWAIT;
            RWAIT:   if (mem_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            icode_q    <= 4'h0;
            stat_q     <= `STAT_RESET;
            valE_q     <= 64'h0;
            valM_q     <= 64'h0;
            dstE_q     <= 4'h0;
            dstM_q     <= 4'h0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= 64'h0;
        end else begin
            state_q <= state_d;
            if (load) begin
                valM_q <= 64'h0;
                if (bubble_i) begin
                    icode_q <= I_NOP;
                    stat_q  <= `STAT_BUBBLE;
                    valE_q  <= 64'h0;
                    dstE_q  <= 4'hF;
                    dstM_q  <= 4'hF;
                end else begin
                    icode_q <= icode_i;
                    stat_q  <= fault ? STAT_ADR : stat_i;
                    valE_q  <= valE_i;
                    dstE_q  <= dstE_i;
                    dstM_q  <= dstM_i;
                    if (start) begin
                        memWe_q    <= isWrite;
                        memAddr_q  <= ADDR_W'(accAddr);
                        memWdata_q <= isWrite ? valA_i : 64'h0;
                    end
                end
            end else if (timeout) begin
                stat_q <= STAT_ADR;
                valM_q <= 64'h0;
            end else if (state_q == RWAIT && mem_rvalid_i) begin
                valM_q <= mem_rdata_i;
            end
        end
    end

    assign mem_req_o   = (state_q == REQ);
    assign mem_busy_o  = (state_q != IDLE);
    assign mem_we_o    = memWe_q;
    assign mem_addr_o  = memAddr_q;
    assign mem_wdata_o = memWdata_q;
    assign icode_o     = icode_q;
    assign stat_o      = stat_q;
    assign valE_o      = valE_q;
    assign valM_o      = valM_q;
    assign dstE_o      = dstE_q;
    assign dstM_o      = dstM_q;

endmodule
